// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: ID-stage interlock controller.
// A two-slot scoreboard (EX, MEM) of in-flight register writers drives
// load-use / RAW stalls. Taken branches raise a multi-cycle fetch flush.
// Data-memory wait states freeze the whole interlock.
// All control outputs are combinational, so they reach the pipeline-register
// enables in the same cycle.
module id_hazard_ctrl #(
  parameter int FORWARDING   = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_validID,
  input  logic [4:0]       i_rdReg1,
  input  logic [4:0]       i_rdReg2,
  input  logic [2:0]       i_ctrlMEM,
  input  logic [6:0]       i_ctrlWB,
  input  logic             i_brTaken,
  input  logic             i_memBusy,
  output logic             o_stallIF,
  output logic             o_stallID,
  output logic             o_stallEX,
  output logic             o_bubbleEX,
  output logic             o_flushIFID,
  output logic             o_flushIDEX,
  output logic [CNT_W-1:0] o_stallCnt
);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic [4:0] rd;
  } slot_t;

  localparam slot_t      SLOT_EMPTY   = 8'h00;
  localparam bit         FWD_EN       = (FORWARDING != 32'sd0);
  localparam bit         FLUSH_MULTI  = (FLUSH_CYCLES > 32'sd1);
  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 32'sd1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // True when a live writer slot targets a nonzero source register of ID.
  function automatic logic slot_hits(input slot_t s, input logic [4:0] r1,
                                     input logic [4:0] r2);
    logic live;
    live = s.valid & s.reg_write & (s.rd != 5'd0);
    return live & (((r1 != 5'd0) & (r1 == s.rd)) | ((r2 != 5'd0) & (r2 == s.rd)));
  endfunction

  slot_t            ex_slot_r, mem_slot_r, id_slot_s;
  state_t           state_r, state_s;
  logic [3:0]       flush_cnt_r, flush_cnt_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             live_r;
  logic             hazard_s, issue_s, slot_adv_s, fsm_adv_s;
  logic             stall_if_s, stall_id_s, stall_ex_s, bubble_s, flush_ifid_s, flush_idex_s;
  logic             unused_ctrl_s;

  // Branch, MemWrite and MemtoReg do not affect the interlock.
  assign unused_ctrl_s = ^{i_ctrlMEM[2], i_ctrlMEM[0], i_ctrlWB[5]};

  // Hazard detection against the EX slot (and MEM slot without forwarding).
  always_comb begin
    logic ex_hit, mem_hit;
    ex_hit  = slot_hits(ex_slot_r, i_rdReg1, i_rdReg2);
    mem_hit = slot_hits(mem_slot_r, i_rdReg1, i_rdReg2);
    if (FWD_EN) begin
      hazard_s = i_validID & ex_hit & ex_slot_r.mem_read;
    end else begin
      hazard_s = i_validID & (ex_hit | mem_hit);
    end
  end

  // Prioritised control outputs; forced quiet until one edge after reset release.
  always_comb begin
    stall_if_s   = 1'b0;
    stall_id_s   = 1'b0;
    stall_ex_s   = 1'b0;
    bubble_s     = 1'b0;
    flush_ifid_s = 1'b0;
    flush_idex_s = 1'b0;
    if (!live_r) begin
      stall_if_s = 1'b0;
    end else if (i_memBusy) begin
      stall_if_s = 1'b1;
      stall_id_s = 1'b1;
      stall_ex_s = 1'b1;
    end else if (i_brTaken) begin
      flush_ifid_s = 1'b1;
      flush_idex_s = 1'b1;
    end else if (state_r == ST_FLUSH) begin
      flush_ifid_s = 1'b1;
    end else if (hazard_s) begin
      stall_if_s = 1'b1;
      stall_id_s = 1'b1;
      bubble_s   = 1'b1;
    end else begin
      stall_if_s = 1'b0;
    end
  end

  // Issue decision and the slot image of the ID instruction.
  always_comb begin
    issue_s    = i_validID & ~hazard_s & ~flush_ifid_s & ~flush_idex_s;
    slot_adv_s = ~live_r | ~i_memBusy;
    fsm_adv_s  = live_r & ~i_memBusy;
    id_slot_s  = {1'b1, i_ctrlWB[6], i_ctrlMEM[1], i_ctrlWB[4:0]};
  end

  // Flush FSM next-state: load on a taken branch, count down, reload on a new branch.
  always_comb begin
    state_s     = state_r;
    flush_cnt_s = flush_cnt_r;
    case (state_r)
      ST_RUN: begin
        if (fsm_adv_s && i_brTaken && FLUSH_MULTI) begin
          state_s     = ST_FLUSH;
          flush_cnt_s = FLUSH_RELOAD;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (!fsm_adv_s) begin
          state_s = ST_FLUSH;
        end else if (i_brTaken) begin
          flush_cnt_s = FLUSH_RELOAD;
        end else if (flush_cnt_r <= 4'd1) begin
          state_s     = ST_RUN;
          flush_cnt_s = 4'd0;
        end else begin
          flush_cnt_s = flush_cnt_r - 4'd1;
        end
      end
      default: begin
        state_s     = ST_RUN;
        flush_cnt_s = 4'd0;
      end
    endcase
  end

  // Reset-release flag plus FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      live_r      <= 1'b0;
      state_r     <= ST_RUN;
      flush_cnt_r <= 4'd0;
    end else begin
      live_r      <= 1'b1;
      state_r     <= state_s;
      flush_cnt_r <= flush_cnt_s;
    end
  end

  // Writer scoreboard: shift EX into MEM and capture the issued ID instruction.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_slot_r  <= SLOT_EMPTY;
      mem_slot_r <= SLOT_EMPTY;
    end else if (slot_adv_s) begin
      mem_slot_r <= ex_slot_r;
      ex_slot_r  <= issue_s ? id_slot_s : SLOT_EMPTY;
    end else begin
      mem_slot_r <= mem_slot_r;
      ex_slot_r  <= ex_slot_r;
    end
  end

  // Saturating count of cycles in which fetch is held.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_if_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign o_stallIF   = stall_if_s;
  assign o_stallID   = stall_id_s;
  assign o_stallEX   = stall_ex_s;
  assign o_bubbleEX  = bubble_s;
  assign o_flushIFID = flush_ifid_s;
  assign o_flushIDEX = flush_idex_s;
  assign o_stallCnt  = stall_cnt_r;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: two instances share stimulus.
// u0: FORWARDING=1, FLUSH_CYCLES=3, CNT_W=16.  u1: FORWARDING=0, FLUSH_CYCLES=2, CNT_W=2.
// Expected flags are {stallIF, stallID, stallEX, bubbleEX, flushIFID, flushIDEX}.
module tb_id_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_id;
  logic [4:0] rs1, rs2;
  logic [2:0] ctrl_mem;
  logic [6:0] ctrl_wb;
  logic       br_taken, mem_busy;

  logic        s_if0, s_id0, s_ex0, bub0, f_ifid0, f_idex0;
  logic [15:0] cnt0;
  logic        s_if1, s_id1, s_ex1, bub1, f_ifid1, f_idex1;
  logic [1:0]  cnt1;

  localparam logic [5:0] NONE  = 6'b000000;
  localparam logic [5:0] STALL = 6'b110100;
  localparam logic [5:0] BUSY  = 6'b111000;
  localparam logic [5:0] BR    = 6'b000011;
  localparam logic [5:0] FL    = 6'b000010;

  localparam logic [2:0] CM_LD  = 3'b010;
  localparam logic [2:0] CM_ALU = 3'b000;

  typedef struct {
    logic        v;
    logic [4:0]  r1, r2;
    logic [2:0]  cm;
    logic [6:0]  cw;
    logic        br, busy;
    logic        sel;
    logic [5:0]  flags;
    logic [15:0] cnt;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[28];
  int   n_total = 0;
  int   n_pass  = 0;

  id_hazard_ctrl #(.FORWARDING(1), .FLUSH_CYCLES(3), .CNT_W(16)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_validID(valid_id), .i_rdReg1(rs1), .i_rdReg2(rs2),
    .i_ctrlMEM(ctrl_mem), .i_ctrlWB(ctrl_wb), .i_brTaken(br_taken), .i_memBusy(mem_busy),
    .o_stallIF(s_if0), .o_stallID(s_id0), .o_stallEX(s_ex0), .o_bubbleEX(bub0),
    .o_flushIFID(f_ifid0), .o_flushIDEX(f_idex0), .o_stallCnt(cnt0));

  id_hazard_ctrl #(.FORWARDING(0), .FLUSH_CYCLES(2), .CNT_W(2)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_validID(valid_id), .i_rdReg1(rs1), .i_rdReg2(rs2),
    .i_ctrlMEM(ctrl_mem), .i_ctrlWB(ctrl_wb), .i_brTaken(br_taken), .i_memBusy(mem_busy),
    .o_stallIF(s_if1), .o_stallID(s_id1), .o_stallEX(s_ex1), .o_bubbleEX(bub1),
    .o_flushIFID(f_ifid1), .o_flushIDEX(f_idex1), .o_stallCnt(cnt1));

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                              input logic [2:0] cm, input logic [6:0] cw, input logic br,
                              input logic busy, input logic sel, input logic [5:0] flags,
                              input logic [15:0] cnt);
    vec_t t;
    t.v = v; t.r1 = r1; t.r2 = r2; t.cm = cm; t.cw = cw; t.br = br; t.busy = busy;
    t.sel = sel; t.flags = flags; t.cnt = cnt;
    return t;
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h expected=%h", name, got, want);
  endtask

  function automatic logic [5:0] flags_of(input logic sel);
    if (sel) return {s_if1, s_id1, s_ex1, bub1, f_ifid1, f_idex1};
    else     return {s_if0, s_id0, s_ex0, bub0, f_ifid0, f_idex0};
  endfunction

  task automatic drive(input vec_t t);
    valid_id = t.v; rs1 = t.r1; rs2 = t.r2; ctrl_mem = t.cm; ctrl_wb = t.cw;
    br_taken = t.br; mem_busy = t.busy;
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare mid-cycle.
  task automatic apply(input vec_t t, input string lbl);
    vec_t e;
    drive(t);
    exp_q.push_back(t);
    @(negedge clk);
    e = exp_q.pop_front();
    chk({lbl, ".flags"}, {10'd0, flags_of(e.sel)}, {10'd0, e.flags});
    chk({lbl, ".cnt"}, e.sel ? {14'd0, cnt1} : cnt0, e.cnt);
    @(posedge clk);
    #1;
  endtask

  // Reset with busy/branch asserted, then release; outputs must stay quiet throughout.
  task automatic do_reset(input string lbl);
    rst_n = 1'b0;
    drive(mk(1'b1, 5'd5, 5'd5, CM_LD, 7'b1100101, 1'b1, 1'b1, 1'b0, NONE, 16'd0));
    @(negedge clk);
    chk({lbl, ".hold.u0"}, {10'd0, flags_of(1'b0)}, 16'd0);
    chk({lbl, ".hold.u1"}, {10'd0, flags_of(1'b1)}, 16'd0);
    chk({lbl, ".hold.cnt0"}, cnt0, 16'd0);
    chk({lbl, ".hold.cnt1"}, {14'd0, cnt1}, 16'd0);
    @(posedge clk);
    #1;
    drive(mk(1'b0, 5'd0, 5'd0, CM_ALU, 7'd0, 1'b0, 1'b0, 1'b0, NONE, 16'd0));
    rst_n = 1'b1;
    @(negedge clk);
    chk({lbl, ".rel.u0"}, {10'd0, flags_of(1'b0)}, 16'd0);
    chk({lbl, ".rel.u1"}, {10'd0, flags_of(1'b1)}, 16'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t ld5, idle;
    ld5  = mk(1'b1, 5'd0, 5'd0, CM_LD, 7'b1100101, 1'b0, 1'b0, 1'b0, NONE, 16'd0);
    idle = mk(1'b0, 5'd0, 5'd0, CM_ALU, 7'd0, 1'b0, 1'b0, 1'b0, NONE, 16'd0);

    // u0 functional table: load-use via rs1/rs2, non-matches, rd=0, branch flushes.
    tbl[0]  = mk(1'b1, 5'd0, 5'd0, CM_LD,  7'b1100101, 1'b0, 1'b0, 1'b0, NONE,  16'd0);
    tbl[1]  = mk(1'b1, 5'd5, 5'd0, CM_ALU, 7'b1001000, 1'b0, 1'b0, 1'b0, STALL, 16'd0);
    tbl[2]  = mk(1'b1, 5'd5, 5'd0, CM_ALU, 7'b1001000, 1'b0, 1'b0, 1'b0, NONE,  16'd1);
    tbl[3]  = mk(1'b1, 5'd0, 5'd0, CM_LD,  7'b1100101, 1'b0, 1'b0, 1'b0, NONE,  16'd1);
    tbl[4]  = mk(1'b1, 5'd6, 5'd0, CM_ALU, 7'b0000000, 1'b0, 1'b0, 1'b0, NONE,  16'd1);
    tbl[5]  = mk(1'b1, 5'd0, 5'd0, CM_LD,  7'b1100000, 1'b0, 1'b0, 1'b0, NONE,  16'd1);
    tbl[6]  = mk(1'b1, 5'd0, 5'd0, CM_ALU, 7'b1001001, 1'b0, 1'b0, 1'b0, NONE,  16'd1);
    tbl[7]  = mk(1'b1, 5'd0, 5'd0, CM_LD,  7'b1100101, 1'b0, 1'b0, 1'b0, NONE,  16'd1);
    tbl[8]  = mk(1'b1, 5'd0, 5'd5, CM_ALU, 7'b1001010, 1'b0, 1'b0, 1'b0, STALL, 16'd1);
    tbl[9]  = mk(1'b1, 5'd0, 5'd5, CM_ALU, 7'b1001010, 1'b0, 1'b0, 1'b0, NONE,  16'd2);
    tbl[10] = mk(1'b1, 5'd0, 5'd0, CM_LD,  7'b1100101, 1'b0, 1'b0, 1'b0, NONE,  16'd2);
    tbl[11] = mk(1'b0, 5'd5, 5'd0, CM_ALU, 7'b1001000, 1'b0, 1'b0, 1'b0, NONE,  16'd2);
    tbl[12] = mk(1'b0, 5'd0, 5'd0, CM_ALU, 7'd0,       1'b0, 1'b0, 1'b0, NONE,  16'd2);
    tbl[13] = mk(1'b1, 5'd0, 5'd0, CM_ALU, 7'b1001011, 1'b1, 1'b0, 1'b0, BR,    16'd2);
    tbl[14] = mk(1'b1, 5'd0, 5'd0, CM_ALU, 7'b1001011, 1'b0, 1'b0, 1'b0, FL,    16'd2);
    tbl[15] = mk(1'b1, 5'd0, 5'd0, CM_ALU, 7'b1001011, 1'b0, 1'b0, 1'b0, FL,    16'd2);
    tbl[16] = mk(1'b1, 5'd0, 5'd0, CM_ALU, 7'b1001011, 1'b0, 1'b0, 1'b0, NONE,  16'd2);
    tbl[17] = mk(1'b0, 5'd0, 5'd0, CM_ALU, 7'd0,       1'b1, 1'b0, 1'b0, BR,    16'd2);
    tbl[18] = mk(1'b0, 5'd0, 5'd0, CM_ALU, 7'd0,       1'b0, 1'b0, 1'b0, FL,    16'd2);
    tbl[19] = mk(1'b0, 5'd0, 5'd0, CM_ALU, 7'd0,       1'b1, 1'b0, 1'b0, BR,    16'd2);
    tbl[20] = mk(1'b0, 5'd0, 5'd0, CM_ALU, 7'd0,       1'b0, 1'b0, 1'b0, FL,    16'd2);
    tbl[21] = mk(1'b0, 5'd0, 5'd0, CM_ALU, 7'd0,       1'b0, 1'b0, 1'b0, FL,    16'd2);
    tbl[22] = mk(1'b0, 5'd0, 5'd0, CM_ALU, 7'd0,       1'b0, 1'b0, 1'b0, NONE,  16'd2);
    tbl[23] = mk(1'b1, 5'd0, 5'd0, CM_LD,  7'b1100101, 1'b0, 1'b0, 1'b0, NONE,  16'd2);
    tbl[24] = mk(1'b1, 5'd5, 5'd0, CM_ALU, 7'b1001000, 1'b1, 1'b0, 1'b0, BR,    16'd2);
    tbl[25] = mk(1'b0, 5'd0, 5'd0, CM_ALU, 7'd0,       1'b0, 1'b0, 1'b0, FL,    16'd2);
    tbl[26] = mk(1'b0, 5'd0, 5'd0, CM_ALU, 7'd0,       1'b0, 1'b0, 1'b0, FL,    16'd2);
    tbl[27] = mk(1'b0, 5'd0, 5'd0, CM_ALU, 7'd0,       1'b0, 1'b0, 1'b0, NONE,  16'd2);

    rst_n = 1'b0;
    drive(idle);
    @(posedge clk);
    #1;
    do_reset("rst0");
    for (int i = 0; i < 28; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // Memory wait during a load-use condition; branch while busy is ignored.
    do_reset("rst1");
    apply(ld5, "busy0");
    apply(mk(1'b1, 5'd5, 5'd0, CM_ALU, 7'b1001000, 1'b0, 1'b1, 1'b0, BUSY,  16'd0), "busy1");
    apply(mk(1'b1, 5'd5, 5'd0, CM_ALU, 7'b1001000, 1'b1, 1'b1, 1'b0, BUSY,  16'd1), "busy2");
    apply(mk(1'b1, 5'd5, 5'd0, CM_ALU, 7'b1001000, 1'b0, 1'b1, 1'b0, BUSY,  16'd2), "busy3");
    apply(mk(1'b1, 5'd5, 5'd0, CM_ALU, 7'b1001000, 1'b0, 1'b1, 1'b0, BUSY,  16'd3), "busy4");
    apply(mk(1'b1, 5'd5, 5'd0, CM_ALU, 7'b1001000, 1'b0, 1'b0, 1'b0, STALL, 16'd4), "busy5");
    apply(mk(1'b1, 5'd5, 5'd0, CM_ALU, 7'b1001000, 1'b0, 1'b0, 1'b0, NONE,  16'd5), "busy6");

    // Reset clears a pending load in the scoreboard and an active flush.
    do_reset("rst2");
    apply(ld5, "rs0");
    do_reset("rst3");
    apply(mk(1'b1, 5'd5, 5'd0, CM_ALU, 7'b1001000, 1'b0, 1'b0, 1'b0, NONE, 16'd0), "rs1");
    apply(mk(1'b0, 5'd0, 5'd0, CM_ALU, 7'd0,       1'b1, 1'b0, 1'b0, BR,   16'd0), "rs2");
    apply(mk(1'b0, 5'd0, 5'd0, CM_ALU, 7'd0,       1'b0, 1'b0, 1'b0, FL,   16'd0), "rs3");
    do_reset("rst4");
    apply(idle, "rs4");
    apply(idle, "rs5");

    // u1: RAW stalls without forwarding, 2-bit counter saturation, 2-cycle flush.
    do_reset("rst5");
    apply(mk(1'b1, 5'd0, 5'd0, CM_ALU, 7'b1000111, 1'b0, 1'b0, 1'b1, NONE,  16'd0), "nf0");
    apply(mk(1'b1, 5'd7, 5'd0, CM_ALU, 7'b1001000, 1'b0, 1'b0, 1'b1, STALL, 16'd0), "nf1");
    apply(mk(1'b1, 5'd7, 5'd0, CM_ALU, 7'b1001000, 1'b0, 1'b0, 1'b1, STALL, 16'd1), "nf2");
    apply(mk(1'b1, 5'd7, 5'd0, CM_ALU, 7'b1001000, 1'b0, 1'b0, 1'b1, NONE,  16'd2), "nf3");
    apply(mk(1'b1, 5'd8, 5'd0, CM_ALU, 7'b1001000, 1'b0, 1'b0, 1'b1, STALL, 16'd2), "nf4");
    apply(mk(1'b1, 5'd8, 5'd0, CM_ALU, 7'b1001000, 1'b0, 1'b0, 1'b1, STALL, 16'd3), "nf5");
    apply(mk(1'b1, 5'd8, 5'd0, CM_ALU, 7'b1001000, 1'b0, 1'b0, 1'b1, NONE,  16'd3), "nf6");
    apply(mk(1'b1, 5'd0, 5'd8, CM_ALU, 7'b1001000, 1'b0, 1'b0, 1'b1, STALL, 16'd3), "nf7");
    apply(mk(1'b1, 5'd0, 5'd8, CM_ALU, 7'b1001000, 1'b0, 1'b0, 1'b1, STALL, 16'd3), "nf8");
    apply(mk(1'b1, 5'd0, 5'd8, CM_ALU, 7'b1001000, 1'b0, 1'b0, 1'b1, NONE,  16'd3), "nf9");
    apply(mk(1'b0, 5'd0, 5'd0, CM_ALU, 7'd0,       1'b1, 1'b0, 1'b1, BR,    16'd3), "nf10");
    apply(mk(1'b0, 5'd0, 5'd0, CM_ALU, 7'd0,       1'b0, 1'b0, 1'b1, FL,    16'd3), "nf11");
    apply(mk(1'b0, 5'd0, 5'd0, CM_ALU, 7'd0,       1'b0, 1'b0, 1'b1, NONE,  16'd3), "nf12");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
- Pipeline interlock controller that sits beside the ID-stage decoder.
- Tracks register writers in flight through EX and MEM with a two-slot scoreboard, built from the decoded ctrlMEM/ctrlWB bundles.
- Sequences stalls, bubbles and flushes for the IF/ID, ID/EX and EX/MEM pipeline registers.
- Covers load-use hazards, taken-branch flushes (with multi-cycle fetch flush) and data-memory wait states, and keeps a stall-cycle performance counter.

Parameters:
- FORWARDING, 1: 1 = EX/MEM forwarding exists, so only load-use stalls; 0 = stall on any RAW against an EX or MEM writer.
- FLUSH_CYCLES, 2: total cycles o_flushIFID stays high per taken branch (1..15).
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_validID  in  1  ID holds a real instruction.
- i_rdReg1  in  5  ID source register 1; 0 = unused.
- i_rdReg2  in  5  ID source register 2; 0 = unused.
- i_ctrlMEM  in  3  ID MEM bundle: [2] Branch, [1] MemRead, [0] MemWrite.
- i_ctrlWB  in  7  ID WB bundle: [6] RegWrite, [5] MemtoReg, [4:0] rd.
- i_brTaken  in  1  branch resolved taken in EX.
- i_memBusy  in  1  data memory not ready; MEM must hold.
- o_stallIF  out  1  hold PC.
- o_stallID  out  1  hold IF/ID.
- o_stallEX  out  1  hold ID/EX and EX/MEM (memory wait only).
- o_bubbleEX  out  1  load NOP into ID/EX.
- o_flushIFID  out  1  clear IF/ID.
- o_flushIDEX  out  1  clear ID/EX.
- o_stallCnt  out  CNT_W  saturating count of cycles with o_stallIF=1.

Behaviour:
- Reset (async, i_rst_n=0): both slots invalid, FSM = RUN, flush counter 0, o_stallCnt 0. All control outputs read 0 while reset is held and on the first cycle after release. Reset mid-flush or mid-stall abandons it; nothing pending survives.
- Slot contents: each slot holds {valid, regWrite, memRead, rd[4:0]}. A slot only counts for hazards when valid=1, regWrite=1 and rd != 0.
- Load-use hazard (combinational): the EX slot is a valid load (memRead=1) and its rd equals a nonzero i_rdReg1 or i_rdReg2, with i_validID=1.
- RAW hazard, FORWARDING=0 only: the same match against the EX slot or the MEM slot, regardless of memRead.
- Output priority, evaluated each cycle (highest first):
  1. i_memBusy=1: o_stallIF = o_stallID = o_stallEX = 1. Slots and FSM frozen. i_brTaken ignored, since EX is held and re-presents it.
  2. i_brTaken=1: o_flushIFID = o_flushIDEX = 1. No stall. FSM goes to FLUSH if FLUSH_CYCLES > 1.
  3. FSM in FLUSH: o_flushIFID = 1.
  4. Hazard: o_stallIF = o_stallID = o_bubbleEX = 1.
  5. Otherwise all 0.
- Scoreboard update on each rising edge when i_memBusy=0:
  - MEM slot <= EX slot.
  - EX slot <= ID instruction if issued, else invalid.
  - Issued = i_validID and no hazard and no flush output asserted this cycle.
  - The ID fields loaded are regWrite = i_ctrlWB[6], memRead = i_ctrlMEM[1], rd = i_ctrlWB[4:0].
- Load-use stall therefore lasts exactly one cycle. With FORWARDING=0 a stall lasts until the writer leaves MEM: 2 cycles for a back-to-back dependency.
- FSM:
  - RUN -> FLUSH on i_brTaken with FLUSH_CYCLES > 1; the counter loads FLUSH_CYCLES-1.
  - FLUSH decrements the counter each non-busy cycle and returns to RUN when it reaches 0.
  - A new i_brTaken while in FLUSH reloads the counter.
- Stall counter: increments on every cycle with o_stallIF=1 and saturates at all-ones (no wrap).
- All outputs are combinational from the registered state and the current inputs: zero latency into the same cycle's pipeline-register enables.

Test Plan:
- Load x5 in EX (ctrlMEM=010, ctrlWB=1_1_00101), ID reads rs1=5 -> one cycle of o_stallIF = o_stallID = o_bubbleEX = 1. The next cycle is clean and the instruction issues. o_stallCnt = 1.
- Same load, ID rs2 = 0 and rs1 = 6; then a load to rd = 0 with rs1 = 0 -> no stall in either case.
- FORWARDING=0: ALU op writes x7, followed immediately by a reader of x7 -> stalled 2 cycles, issues on cycle 3.
- i_brTaken pulse, FLUSH_CYCLES=3 -> o_flushIFID high 3 cycles, o_flushIDEX high 1 cycle. No bubble, no stall. FSM back in RUN on cycle 4.
- i_memBusy held 4 cycles during a load-use condition -> o_stallEX = 1 for 4 cycles, slots frozen. Afterward a single load-use stall cycle. o_stallCnt = 5.
- Assert i_rst_n=0 mid-FLUSH, then release -> all outputs 0, slots empty, no residual flush. CNT_W=2 with 5 stall cycles -> o_stallCnt saturates at 3.
